// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the slice-serial carry-lookahead adder:
// FSM state encoding and the slice width.
package cla_seq_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_gp_slice.sv
// Combinational 4-bit carry-lookahead slice: generate/propagate terms, the
// internal carry chain, the slice sum, and the carries into bit 3 and out of bit 3.
module cla_gp_slice
  import cla_seq_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c0,
  output logic [SLICE_W-1:0] sum,
  output logic               c3,
  output logic               c4
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum = p ^ c[SLICE_W-1:0];
  assign c3  = c[SLICE_W-1];
  assign c4  = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Slice-serial adder: one carry-lookahead slice is reused for WIDTH/4 cycles,
// walking from the least significant slice up, with a ready/valid handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for in_valid; last result still on sum
// ST_RUN  | one 4-bit slice per cycle, slice k, carry chained via reg
// ST_DONE | out_valid=1, result held until out_ready
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = $clog2(NSLICE);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t             state;
  logic [KW-1:0]      k;
  logic               carry;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_c3;
  logic               s_c4;

  // Operand slice select: the single slice instance sees slice k each cycle.
  always_comb begin
    s_a = '0;
    s_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) begin
        s_a = a_reg[i*SLICE_W +: SLICE_W];
        s_b = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_gp_slice u_slice (
    .a   (s_a),
    .b   (s_b),
    .c0  (carry),
    .sum (s_sum),
    .c3  (s_c3),
    .c4  (s_c4)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (k == KW'(i)) begin
              sum[i*SLICE_W +: SLICE_W] <= s_sum;
            end
          end
          carry <= s_c4;
          // k stops at the last slice so it never wraps inside RUN.
          if (k == K_LAST) begin
            cout  <= s_c4;
            ovf   <= s_c3 ^ s_c4;
            state <= ST_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NSLICE = WIDTH/4: number of 4-bit slices, which is also the number of cycles spent in RUN.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 Port in_valid, input, 1 bit: operand set offered.
REQ-006 Port in_ready, output, 1 bit: block can accept an operand set.
REQ-007 Port a and port b, inputs, WIDTH bits each: addends, sampled on acceptance only.
REQ-008 Port cin, input, 1 bit: carry-in, sampled on acceptance only.
REQ-009 Port out_valid, output, 1 bit: result available.
REQ-010 Port out_ready, input, 1 bit: consumer takes the result.
REQ-011 Port sum, output, WIDTH bits: registered result.
REQ-012 Port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 Port ovf, output, 1 bit: two's-complement overflow, equal to the carry into bit WIDTH-1 XOR cout.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE, with in_valid=1: on the clock edge, latch a, b and cin, clear slice counter k to 0, clear the sum register, go to RUN.
REQ-016 RUN, each cycle, slice k (bits 4k+3..4k): g=a&b, p=a^b, c0=carry register, c[i+1]=g[i] | (p[i]&c[i]), sum bits = p ^ c[3:0].
REQ-017 RUN, same edge: write the 4 sum bits into slice k of the sum register, load the carry register with c[4], increment k.
REQ-018 RUN, on the edge where k==NSLICE-1: load cout=c[4] and ovf=c[3]^c[4], go to DONE.
REQ-019 DONE: hold sum, cout and ovf stable; on an edge with out_ready=1, go to IDLE.
REQ-020 sum, cout and ovf SHALL keep their values through IDLE until the next acceptance clears them.
REQ-021 Latency: out_valid SHALL rise exactly NSLICE cycles after the acceptance edge.
REQ-022 Throughput: one operation per NSLICE+2 cycles when out_ready is held at 1.
REQ-023 There is no overlap: in_ready=0 throughout RUN and DONE, and in_valid is ignored outside IDLE.
REQ-024 Operand changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with cout as the only carry beyond bit WIDTH-1.
REQ-026 Slice counter k SHALL be ceil(log2(NSLICE)) bits wide and never wrap inside RUN.
REQ-027 out_ready=1 while not in DONE SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE and clear k, carry register, sum, cout and ovf to 0, regardless of state, including mid-RUN.
REQ-029 A reset during RUN or DONE SHALL discard the operation with no out_valid pulse.
REQ-030 Reset output values: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
REQ-031 No transfer SHALL occur while rst_n=0.
REQ-032 The first acceptance is possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, RUN=1, DONE=2) and the slice width constant 4.
REQ-034 Sub-module cla_gp_slice SHALL be purely combinational.
REQ-035 cla_gp_slice inputs: a, b (4 bits each), c0. Outputs: sum (4 bits), c3 (carry into bit 3), c4 (carry out).
REQ-036 cla_gp_slice SHALL be instantiated once and reused every RUN cycle through a multiplexer indexed by k.

Verification
REQ-037 WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after acceptance, sum=0x0000, cout=1, ovf=0.
REQ-038 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-039 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0; a and b toggled randomly during RUN -> result unchanged.
REQ-040 Result ready with out_ready=0 for 3 cycles -> out_valid, sum and cout held stable and in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-041 rst_n pulsed low at k=2 -> outputs zero and in_ready=1 immediately; no out_valid afterwards; next operation a=0x0001, b=0x0001 -> sum=0x0002.
REQ-042 Back-to-back: in_valid held at 1 with out_ready=1 over 100 random operand sets -> every sum, cout and ovf matches a reference model, with one operation every 6 cycles.
